// File: rtl/wav_byte_fetch_pkg.sv
// Shared types and the byte-lane helper for the wave byte fetcher.
package wav_byte_fetch_pkg;

  typedef logic [63:0] ddr_word_t;
  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  byte_off_t;

  // Little-endian lane select: offset 0 is bits [7:0].
  function automatic byte_t byte_sel(input ddr_word_t word, input byte_off_t off);
    return word[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wav_byte_fetch.sv
// Byte-read front end for wave_sound: caches the current DDRAM word, prefetches the next,
// and talks to the DDRAM toggle-handshake port.
module wav_byte_fetch
  import wav_byte_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 28,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd,
  output logic [7:0]        rd_data,
  output logic              rd_ready,
  output logic [ADDR_W-4:0] s_addr,
  output logic              s_rd,
  input  logic              s_ack,
  input  logic [63:0]       s_dout
);

  localparam int unsigned TagW = ADDR_W - 3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StPref = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            rd_q;
  logic            rd_ready_q, rd_ready_d;
  byte_t           rd_data_q, rd_data_d;
  logic [TagW-1:0] req_tag_q, req_tag_d;
  byte_off_t       req_off_q, req_off_d;
  logic [TagW-1:0] cur_tag_q, cur_tag_d;
  ddr_word_t       cur_word_q, cur_word_d;
  logic            cur_valid_q, cur_valid_d;
  logic [TagW-1:0] nxt_tag_q, nxt_tag_d;
  ddr_word_t       nxt_word_q, nxt_word_d;
  logic            nxt_valid_q, nxt_valid_d;
  logic            pref_flushed_q, pref_flushed_d;
  // Handshake outputs survive reset so a stale ack can be matched against them.
  logic            s_rd_q = 1'b0;
  logic            s_rd_d;
  logic [TagW-1:0] s_addr_q = '0;
  logic [TagW-1:0] s_addr_d;

  logic pending;
  logic req_edge;
  logic cur_hit;
  logic nxt_hit;

  assign pending  = s_rd_q ^ s_ack;
  // Only one request may be outstanding; edges while rd_ready is low are dropped.
  assign req_edge = rd & ~rd_q & rd_ready_q;
  assign cur_hit  = cur_valid_q && !flush && (cur_tag_q == req_tag_q);
  assign nxt_hit  = nxt_valid_q && !flush && (nxt_tag_q == req_tag_q);

  always_comb begin
    state_d        = state_q;
    rd_ready_d     = rd_ready_q;
    rd_data_d      = rd_data_q;
    req_tag_d      = req_tag_q;
    req_off_d      = req_off_q;
    cur_tag_d      = cur_tag_q;
    cur_word_d     = cur_word_q;
    cur_valid_d    = cur_valid_q;
    nxt_tag_d      = nxt_tag_q;
    nxt_word_d     = nxt_word_q;
    nxt_valid_d    = nxt_valid_q;
    pref_flushed_d = pref_flushed_q;
    s_rd_d         = s_rd_q;
    s_addr_d       = s_addr_q;

    if (flush) begin
      cur_valid_d = 1'b0;
      nxt_valid_d = 1'b0;
    end

    if (req_edge) begin
      rd_ready_d = 1'b0;
      req_tag_d  = rd_addr[ADDR_W-1:3];
      req_off_d  = rd_addr[2:0];
    end

    case (state_q)
      StIdle: begin
        if (!rd_ready_q) begin
          if (cur_hit) begin
            rd_data_d  = byte_sel(cur_word_q, req_off_q);
            rd_ready_d = 1'b1;
          end else if (nxt_hit) begin
            cur_tag_d   = nxt_tag_q;
            cur_word_d  = nxt_word_q;
            cur_valid_d = 1'b1;
            nxt_valid_d = 1'b0;
            rd_data_d   = byte_sel(nxt_word_q, req_off_q);
            rd_ready_d  = 1'b1;
          end else if (!pending) begin
            s_rd_d   = ~s_rd_q;
            s_addr_d = req_tag_q;
            state_d  = StFill;
          end
        end else if (PREFETCH && cur_valid_q && !nxt_valid_q && !pending && !flush) begin
          s_rd_d         = ~s_rd_q;
          s_addr_d       = cur_tag_q + TagW'(1);
          pref_flushed_d = 1'b0;
          state_d        = StPref;
        end
      end
      StFill: begin
        if (!pending) begin
          cur_tag_d   = req_tag_q;
          cur_word_d  = s_dout;
          cur_valid_d = !flush;
          rd_data_d   = byte_sel(s_dout, req_off_q);
          rd_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      StPref: begin
        if (flush) begin
          pref_flushed_d = 1'b1;
        end
        // A flush anywhere in the prefetch window makes the returned word untrustworthy.
        if (!pending) begin
          nxt_tag_d   = s_addr_q;
          nxt_word_d  = s_dout;
          nxt_valid_d = !flush && !pref_flushed_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    rd_q <= rd;
    if (!reset) begin
      s_rd_q   <= s_rd_d;
      s_addr_q <= s_addr_d;
    end
    if (reset) begin
      state_q        <= StIdle;
      rd_ready_q     <= 1'b1;
      rd_data_q      <= '0;
      req_tag_q      <= '0;
      req_off_q      <= '0;
      cur_tag_q      <= '0;
      cur_word_q     <= '0;
      cur_valid_q    <= 1'b0;
      nxt_tag_q      <= '0;
      nxt_word_q     <= '0;
      nxt_valid_q    <= 1'b0;
      pref_flushed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ready_q     <= rd_ready_d;
      rd_data_q      <= rd_data_d;
      req_tag_q      <= req_tag_d;
      req_off_q      <= req_off_d;
      cur_tag_q      <= cur_tag_d;
      cur_word_q     <= cur_word_d;
      cur_valid_q    <= cur_valid_d;
      nxt_tag_q      <= nxt_tag_d;
      nxt_word_q     <= nxt_word_d;
      nxt_valid_q    <= nxt_valid_d;
      pref_flushed_q <= pref_flushed_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ready = rd_ready_q;
  assign s_rd     = s_rd_q;
  assign s_addr   = s_addr_q;

endmodule

// File: tb/tb_wav_byte_fetch.sv
// Bench for wav_byte_fetch: a DDRAM toggle-port model backed by an address-derived memory.
module tb_wav_byte_fetch;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        flush   = 1'b0;
  logic        rd      = 1'b0;
  logic [27:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [24:0] s_addr;
  logic        s_rd;
  logic        s_ack   = 1'b0;
  logic [63:0] s_dout  = '0;

  int tests = 0;
  int fails = 0;
  int pat_sel = 0;
  int lat = 10;

  // DDRAM model state
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [24:0] req_a = '0;
  logic [24:0] issued[$];
  int          acks = 0;
  logic        s_rd_prev = 1'b0;
  logic        early = 1'b0;

  wav_byte_fetch #(.ADDR_W(28), .PREFETCH(1'b1)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .flush   (flush),
    .rd_addr (rd_addr),
    .rd      (rd),
    .rd_data (rd_data),
    .rd_ready(rd_ready),
    .s_addr  (s_addr),
    .s_rd    (s_rd),
    .s_ack   (s_ack),
    .s_dout  (s_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [24:0] wa);
    if (pat_sel == 0) return 64'h0706050403020100;
    return {32'(wa) * 32'h9E3779B1, 32'(wa) ^ 32'hC3A50F1E};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [27:0] a);
    logic [63:0] w;
    w = mem_word(a[27:3]);
    return w[8*a[2:0] +: 8];
  endfunction

  function automatic logic [24:0] issued_at(input int i);
    if (i < issued.size()) return issued[i];
    return 'x;
  endfunction

  always @(posedge clk) begin
    if (busy) begin
      if (cnt == 1) begin
        s_ack  <= ~s_ack;
        s_dout <= mem_word(req_a);
        busy   <= 1'b0;
        acks   <= acks + 1;
      end
      cnt <= cnt - 1;
    end else if (s_rd != s_ack) begin
      busy  <= 1'b1;
      cnt   <= lat;
      req_a <= s_addr;
      issued.push_back(s_addr);
    end
  end

  // A toggle while a read is still unacknowledged would corrupt the handshake.
  always @(posedge clk) begin
    s_rd_prev <= s_rd;
    if (s_rd !== s_rd_prev && busy) early <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_read(input logic [27:0] a, input logic with_flush);
    @(negedge clk);
    rd_addr = a;
    rd      = 1'b1;
    flush   = with_flush;
    @(negedge clk);
    rd    = 1'b0;
    flush = 1'b0;
    chk("ready_drop", 64'(rd_ready), 64'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (rd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 64'(rd_ready), 64'd1);
  endtask

  task automatic do_read(input logic [27:0] a, input logic with_flush, output int n);
    start_read(a, with_flush);
    wait_ready(n);
    chk($sformatf("data@%0h", a), 64'(rd_data), 64'(ref_byte(a)));
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    int ab;
    logic [27:0] a;
    logic [2:0]  r;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 64'(rd_ready), 64'd1);
    chk("reset_data", 64'(rd_data), 64'd0);
    chk("reset_srd", 64'(s_rd), 64'd0);

    // Cold read and lane check
    pat_sel = 0;
    n0 = issued.size();
    do_read(28'h10, 1'b0, n);
    chk("cold_one_toggle", 64'(issued.size() - n0), 64'd1);
    chk("cold_saddr", 64'(issued_at(n0)), 64'h2);
    repeat (30) @(negedge clk);
    chk("cold_pref_saddr", 64'(issued_at(n0 + 1)), 64'h3);
    do_read(28'h13, 1'b0, n);
    chk("lane_0x13", 64'(rd_data), 64'h03);
    chk("lane_latency", 64'(n), 64'd2);

    // Sequential bytes with 10-clock ack latency
    pat_sel = 1;
    pulse_flush();
    lat = 10;
    n0 = issued.size();
    for (int i = 0; i < 16; i++) begin
      do_read(28'(i), 1'b0, n);
      if (i >= 8) chk($sformatf("seq_latency_%0d", i), 64'(n), 64'd2);
      repeat (15) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("seq_toggles", 64'(issued.size() - n0), 64'd3);
    chk("seq_line0", 64'(issued_at(n0)), 64'd0);
    chk("seq_line1", 64'(issued_at(n0 + 1)), 64'd1);
    chk("seq_line2", 64'(issued_at(n0 + 2)), 64'd2);

    // Request for line 5 while the line-1 prefetch is in flight
    pulse_flush();
    n0 = issued.size();
    do_read(28'h3, 1'b0, n);
    r = 3'($urandom_range(0, 7));
    do_read(28'h28 | 28'(r), 1'b0, n);
    chk("pref_hold", 64'(n > 10), 64'd1);
    repeat (40) @(negedge clk);
    chk("pref_toggles", 64'(issued.size() - n0), 64'd3);
    chk("pref_order_0", 64'(issued_at(n0)), 64'd0);
    chk("pref_order_1", 64'(issued_at(n0 + 1)), 64'd1);
    chk("pref_order_5", 64'(issued_at(n0 + 2)), 64'd5);
    chk("pref_no_lost", 64'(s_rd ^ s_ack), 64'd0);
    do_read(28'h8 | 28'(r), 1'b0, n);
    chk("nxt_kept_latency", 64'(n), 64'd2);
    repeat (30) @(negedge clk);

    // Prefetch wraps from the top line to line 0
    pulse_flush();
    n0 = issued.size();
    r = 3'($urandom_range(0, 7));
    do_read(28'hFFFFFF8 | 28'(r), 1'b0, n);
    repeat (30) @(negedge clk);
    chk("wrap_fill", 64'(issued_at(n0)), 64'h1FFFFFF);
    chk("wrap_pref", 64'(issued_at(n0 + 1)), 64'd0);
    do_read(28'(r), 1'b0, n);
    chk("wrap_hit_latency", 64'(n), 64'd2);
    repeat (30) @(negedge clk);

    // Flush invalidates cached lines
    pulse_flush();
    n0 = issued.size();
    do_read(28'h5, 1'b0, n);
    chk("flush_refill", 64'(issued_at(n0)), 64'd0);
    chk("flush_miss_latency", 64'(n > 2), 64'd1);
    repeat (30) @(negedge clk);
    n0 = issued.size();
    do_read(28'hA, 1'b1, n);
    chk("edge_flush_miss", 64'(issued_at(n0)), 64'd1);
    repeat (30) @(negedge clk);

    // Randomised reads against the memory model
    for (int k = 0; k < 40; k++) begin
      lat = $urandom_range(1, 12);
      a = 28'($urandom_range(0, 79));
      if (k % 7 == 3) a = 28'($urandom);
      do_read(a, ($urandom_range(0, 5) == 0), n);
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // Reset in the middle of a fill, stale ack five clocks later
    lat = 10;
    n0 = issued.size();
    start_read(28'h0123450, 1'b0);
    n = 0;
    while (issued.size() == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_fill_issued", 64'(issued.size() - n0), 64'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 64'(rd_ready), 64'd1);
    chk("rst_mid_data", 64'(rd_data), 64'd0);
    ab = acks;
    r = 3'($urandom_range(0, 7));
    do_read(28'h0ABCDE8 | 28'(r), 1'b0, n);
    chk("rst_two_acks", 64'(acks - ab), 64'd2);
    chk("rst_no_early_toggle", 64'(early), 64'd0);
    do_read(28'h0123450, 1'b0, n);
    chk("rst_stale_not_cached", 64'(n > 2), 64'd1);

    repeat (40) @(negedge clk);
    chk("final_no_lost", 64'(s_rd ^ s_ack), 64'd0);
    chk("final_no_early", 64'(early), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
